pipe_trace_buffer: RTL and testbench
====================================

Name: pipe_trace_buffer

Overview:
- Synthesizable, parametrised trace capture for the 3-stage 16-bit CPU.
- Samples CHANNELS pipeline-state words per enabled cycle into a circular buffer of DEPTH entries.
- Stops capture POST samples after a trigger, then allows oldest-first readout.
- Sits beside top. It replaces per-cycle dumps with an on-chip pre/post-trigger window readable by bench or debug logic.

Parameters:
WIDTH, 16, bits per channel word
CHANNELS, 4, channels captured per sample (e.g. instr, alu result, R1 data, PC)
DEPTH, 32, buffer entries; power of two, >= 4
PTR_W, $clog2(DEPTH), pointer width (derived)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
arm  in  1  pulse; start a new capture
trig_in  in  1  trigger qualifier (e.g. halt_sys, stall)
post_count  in  PTR_W  samples to take after the trigger sample; sampled on the trigger cycle
sample_en  in  1  capture this cycle (tie to ~stall to skip bubbles)
ch_data  in  CHANNELS*WIDTH  channel words; ch0 in the LSBs
rd_req  in  1  pop one entry
rd_valid  out  1  rd_data valid this cycle
rd_data  out  CHANNELS*WIDTH  popped entry
rd_empty  out  1  no unread entries
done  out  1  capture complete
triggered  out  1  trigger seen this capture
wrapped  out  1  buffer has overwritten at least once
trig_index  out  PTR_W  buffer slot holding the trigger sample
level  out  PTR_W+1  unread entries (DONE) / stored entries (capturing)

Behaviour:
- Reset (rst=0, async), all outputs: state IDLE; rd_valid 0; rd_data 0; rd_empty 1; done 0; triggered 0; wrapped 0; trig_index 0; level 0; internal pointers 0. Buffer RAM is not reset.
- States: IDLE, ARMED, POST, DONE.
- IDLE:
  - arm -> ARMED.
  - Clears wr_ptr, level, wrapped, triggered and done.
  - trig_in and sample_en are ignored.
- ARMED, on each sample_en cycle:
  - Write ch_data to mem[wr_ptr]; wr_ptr increments mod DEPTH.
  - wr_ptr wrapping DEPTH-1 -> 0 sets wrapped.
  - level saturates at DEPTH.
- ARMED, trigger on trig_in & sample_en:
  - The trigger sample is written.
  - trig_index = wr_ptr before increment; triggered = 1.
  - post_left = min(post_count, DEPTH-1).
  - If post_left == 0 -> DONE next cycle; else -> POST.
  - trig_in without sample_en is ignored.
- POST:
  - Each sample_en cycle writes as in ARMED and decrements post_left.
  - The write that takes post_left to 0 -> DONE.
  - trig_in is ignored.
- DONE:
  - done = 1; capture is frozen.
  - rd_ptr = wrapped ? wr_ptr : 0 (oldest entry); level = stored count.
- Readout (DONE only):
  - rd_req & !rd_empty -> rd_data = mem[rd_ptr] and rd_valid = 1 on the next cycle (1-cycle latency).
  - rd_ptr increments mod DEPTH; level decrements.
  - rd_req when rd_empty: no effect, rd_valid stays 0.
  - Back-to-back rd_req gives one entry per cycle.
  - rd_data holds its last value when rd_valid = 0.
- arm handling:
  - arm in ARMED or POST is ignored.
  - arm in DONE discards unread entries; the state goes to ARMED, with the same clearing as from IDLE.
  - arm and rd_req in the same cycle: arm wins and no pop occurs.
- rd_empty = (level == 0) in DONE; forced 1 in all other states.
- Reset asserted mid-POST or mid-readout: immediate return to the reset values above. The next arm behaves as after power-up.

Test Plan:
- Basic window (DEPTH=8, CHANNELS=2)
  - Stimulus: arm; feed ch0=i, ch1=16'hFFFF-i for i=0..5, sample_en=1; trig_in at i=3; post_count=2.
  - Required: DONE after the i=5 write; trig_index=3; wrapped=0; level=6; reads return i=0..5 in order, each 1 cycle after rd_req; then rd_empty=1.
- Wrap-around
  - Stimulus: i=0..19; trig at i=15; post_count=2.
  - Required: wrapped=1; trig_index=7; level=8; reads return i=10..17 oldest-first.
- sample_en gating
  - Stimulus: sample_en toggles every cycle; trig_in held high on a disabled cycle, then on the next enabled cycle; post_count=3.
  - Required: only enabled samples are stored; the trigger is taken on the enabled cycle; DONE after exactly 3 further enabled samples.
- Zero post-count and clamp
  - post_count=0: DONE the cycle after the trigger; the last entry read is the trigger sample.
  - post_count=15 with DEPTH=8: clamps to 7; the buffer holds the trigger sample plus 7 post samples.
- Async reset mid-capture
  - Stimulus: drop rst during POST, then during readout.
  - Required: outputs take reset values without a clock edge; rd_empty=1. After re-arm, the basic window scenario passes unchanged.
- Control collisions
  - Stimulus: arm during ARMED; arm+rd_req in DONE after 2 pops; rd_req when empty.
  - Required: first arm ignored; second arm discards the rest (level=0, state ARMED, no rd_valid); empty pop gives rd_valid=0.

Source files
------------

// File: rtl/pipe_trace_buffer.sv
// Pre/post-trigger trace capture: samples CHANNELS words per enabled cycle
// into a circular buffer, freezes POST samples after a trigger, then pops
// the captured window oldest-first with one cycle of read latency.
module pipe_trace_buffer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 32,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      trig_in,
  input  logic [PTR_W-1:0]          post_count,
  input  logic                      sample_en,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic                      rd_req,
  output logic                      rd_valid,
  output logic [CHANNELS*WIDTH-1:0] rd_data,
  output logic                      rd_empty,
  output logic                      done,
  output logic                      triggered,
  output logic                      wrapped,
  output logic [PTR_W-1:0]          trig_index,
  output logic [PTR_W:0]            level
);

  localparam int               WORD_W    = CHANNELS * WIDTH;
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   LEVEL_MAX = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  post_left;

  logic do_clear;
  logic do_write;
  logic do_trig;
  logic do_pop;
  logic wr_last_slot;
  logic enter_done;

  // At most DEPTH-1 post samples fit, otherwise the trigger sample is lost.
  function automatic logic [PTR_W-1:0] clamp_post(input logic [PTR_W-1:0] v);
    if (int'(v) > DEPTH - 1) return LAST_SLOT;
    return v;
  endfunction

  // Stored-entry count stops at DEPTH once the buffer starts overwriting.
  function automatic logic [PTR_W:0] sat_inc_level(input logic [PTR_W:0] l);
    if (l == LEVEL_MAX) return l;
    return l + 1'b1;
  endfunction

  // Decode the per-cycle actions shared by the FSM and the datapath.
  always_comb begin
    do_clear     = (state == S_IDLE) || ((state == S_DONE) && arm);
    do_write     = ((state == S_ARMED) || (state == S_POST)) && sample_en;
    do_trig      = (state == S_ARMED) && sample_en && trig_in;
    do_pop       = (state == S_DONE) && !arm && rd_req && (level != '0);
    wr_last_slot = (wr_ptr == LAST_SLOT);
    enter_done   = (state != S_DONE) && (state_nxt == S_DONE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a trigger without sample_en never counts.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arm) state_nxt = S_ARMED;
      S_ARMED: if (do_trig)
                 state_nxt = (clamp_post(post_count) == '0) ? S_DONE : S_POST;
      S_POST:  if (sample_en && (post_left == PTR_W'(1))) state_nxt = S_DONE;
      S_DONE:  if (arm) state_nxt = S_ARMED;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture RAM has no reset; only enabled capture cycles write it.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= ch_data;
  end

  // Pointers, counters, trigger bookkeeping and the registered read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      triggered  <= 1'b0;
      wrapped    <= 1'b0;
      trig_index <= '0;
      level      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_left  <= '0;
    end else begin
      rd_valid <= 1'b0;

      if (do_clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        wrapped   <= 1'b0;
        triggered <= 1'b0;
      end

      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
        level  <= sat_inc_level(level);
        if (wr_last_slot) wrapped <= 1'b1;
      end

      if (do_trig) begin
        trig_index <= wr_ptr;
        triggered  <= 1'b1;
        post_left  <= clamp_post(post_count);
      end else if ((state == S_POST) && sample_en) begin
        post_left <= post_left - 1'b1;
      end

      // Entry into DONE always coincides with a write, so wr_ptr+1 is the
      // slot after the newest sample, i.e. the oldest one once wrapped.
      if (enter_done) rd_ptr <= (wrapped || wr_last_slot) ? wr_ptr + 1'b1 : '0;

      if (do_pop) begin
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
        rd_ptr   <= rd_ptr + 1'b1;
        level    <= level - 1'b1;
      end
    end
  end

  assign done     = (state == S_DONE);
  assign rd_empty = (state == S_DONE) ? (level == '0) : 1'b1;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer (DEPTH=8, CHANNELS=2): table-driven windows,
// hand-written corner sequences and randomized captures against a queue model.
module tb_pipe_trace_buffer;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 8;
  localparam int PTR_W    = 3;
  localparam int WORD_W   = WIDTH * CHANNELS;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm;
  logic              trig_in;
  logic [PTR_W-1:0]  post_count;
  logic              sample_en;
  logic [WORD_W-1:0] ch_data;
  logic              rd_req;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_data;
  logic              rd_empty;
  logic              done;
  logic              triggered;
  logic              wrapped;
  logic [PTR_W-1:0]  trig_index;
  logic [PTR_W:0]    level;

  pipe_trace_buffer #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_in(trig_in),
    .post_count(post_count), .sample_en(sample_en), .ch_data(ch_data),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_empty(rd_empty), .done(done), .triggered(triggered),
    .wrapped(wrapped), .trig_index(trig_index), .level(level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WORD_W-1:0] word_of(input int i);
    return {16'(16'hFFFF - i), 16'(i)};
  endfunction

  // Reference model: every accepted sample of the current capture in order.
  logic [WORD_W-1:0] hist[$];
  bit m_active, m_trig, m_done;
  int m_post_left, m_trig_pos;

  function automatic void model_reset();
    hist.delete();
    m_active = 0; m_trig = 0; m_done = 0;
  endfunction

  function automatic void model_arm();
    hist.delete();
    m_active = 1; m_trig = 0; m_done = 0;
  endfunction

  function automatic void model_sample(input logic [WORD_W-1:0] d, input bit trg, input int pc);
    bit fin;
    if (!m_active) return;
    hist.push_back(d);
    fin = 0;
    if (!m_trig) begin
      if (trg) begin
        m_trig      = 1;
        m_trig_pos  = hist.size() - 1;
        m_post_left = (pc > DEPTH - 1) ? DEPTH - 1 : pc;
        fin = (m_post_left == 0);
      end
    end else begin
      m_post_left--;
      fin = (m_post_left == 0);
    end
    if (fin) begin
      m_active = 0;
      m_done   = 1;
    end
  endfunction

  function automatic int model_stored();
    return (hist.size() < DEPTH) ? hist.size() : DEPTH;
  endfunction

  function automatic logic [WORD_W-1:0] model_entry(input int k);
    return hist[hist.size() - model_stored() + k];
  endfunction

  task automatic drive_cycle(input bit en, input bit trg, input logic [WORD_W-1:0] d, input int pc);
    int pc_port;
    pc_port    = pc % DEPTH;  // the field is PTR_W bits wide
    sample_en  = en;
    trig_in    = trg;
    ch_data    = d;
    post_count = PTR_W'(pc_port);
    tick();
    if (en) model_sample(d, trg, pc_port);
    check("done", done, m_done);
    check("triggered", triggered, m_trig);
    sample_en = 1'b0;
    trig_in   = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    model_arm();
    check("arm_done_low", done, 0);
    check("arm_empty", rd_empty, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_empty"}, rd_empty, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_triggered"}, triggered, 0);
    check({tag, "_wrapped"}, wrapped, 0);
    check({tag, "_trig_index"}, trig_index, 0);
    check({tag, "_level"}, level, 0);
  endtask

  // Pops n entries back-to-back, then one pop on an empty buffer.
  task automatic read_all(input int n, input bit use_table, input int first);
    logic [WORD_W-1:0] exp;
    exp = '0;
    check("pre_read_valid", rd_valid, 0);
    for (int k = 0; k < n; k++) begin
      rd_req = 1'b1;
      exp = use_table ? word_of(first + k) : model_entry(k);
      tick();
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, exp);
      check("rd_level", level, n - k - 1);
    end
    tick();
    check("empty_pop_valid", rd_valid, 0);
    check("empty_pop_hold", rd_data, exp);
    check("empty_flag", rd_empty, 1);
    rd_req = 1'b0;
  endtask

  typedef struct {
    int trig_at;
    int post;
    int total;
    int exp_ti;
    bit exp_wrap;
    int exp_level;
    int first;
  } vec_t;

  vec_t vecs[5];

  task automatic capture_vec(input vec_t v);
    do_arm();
    for (int i = 0; i < v.total; i++) begin
      drive_cycle(1'b1, i == v.trig_at, word_of(i), v.post);
      if (i == v.total - 2) check("vec_not_done_early", done, 0);
    end
    check("vec_done", done, 1);
    check("vec_trig_index", trig_index, v.exp_ti);
    check("vec_wrapped", wrapped, v.exp_wrap);
    check("vec_level", level, v.exp_level);
    check("vec_empty", rd_empty, 0);
  endtask

  task automatic run_vec(input vec_t v);
    capture_vec(v);
    read_all(v.exp_level, 1'b1, v.first);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; arm = 1'b0; trig_in = 1'b0; post_count = '0;
    sample_en = 1'b0; ch_data = '0; rd_req = 1'b0;
    model_reset();

    // trig_at, post, total samples, trig_index, wrapped, level, first read
    vecs[0] = '{3, 2, 6, 3, 1'b0, 6, 0};    // basic window
    vecs[1] = '{15, 2, 18, 7, 1'b1, 8, 10}; // wrap-around
    vecs[2] = '{2, 0, 3, 2, 1'b0, 3, 0};    // zero post: last read is trigger
    vecs[3] = '{4, 15, 12, 4, 1'b1, 8, 4};  // 15 in a 3-bit field is 7 = max
    vecs[4] = '{7, 0, 8, 7, 1'b1, 8, 0};    // exactly DEPTH samples

    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b1;
    tick();
    check_reset_vals("idle");

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // sample_en gating: trigger held over a disabled then an enabled cycle
    do_arm();
    for (int c = 0; c < 12; c++) begin
      drive_cycle(c % 2 == 0, (c == 3) || (c == 4), word_of(c), 3);
      check("gate_done", done, c >= 10);
    end
    check("gate_trig_index", trig_index, 2);
    check("gate_level", level, 6);
    check("gate_wrapped", wrapped, 0);
    read_all(6, 1'b0, 0);

    // Async reset in POST
    do_arm();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, i == 3, word_of(i), 2);
    #2 rst = 1'b0;
    #1 check_reset_vals("rst_post");
    model_reset();
    tick();
    rst = 1'b1;
    run_vec(vecs[0]);

    // Async reset during readout
    capture_vec(vecs[0]);
    rd_req = 1'b1;
    tick();
    tick();
    rd_req = 1'b0;
    check("pre_rst_data", rd_data, word_of(1));
    #2 rst = 1'b0;
    #1 check_reset_vals("rst_read");
    model_reset();
    tick();
    rst = 1'b1;
    run_vec(vecs[0]);

    // Control collisions
    do_arm();
    rd_req = 1'b1;
    drive_cycle(1'b1, 1'b0, word_of(0), 1);
    check("armed_pop_ignored", rd_valid, 0);
    rd_req = 1'b0;
    drive_cycle(1'b1, 1'b0, word_of(1), 1);
    arm = 1'b1;
    drive_cycle(1'b1, 1'b0, word_of(2), 1);
    arm = 1'b0;
    drive_cycle(1'b1, 1'b1, word_of(3), 1);
    drive_cycle(1'b1, 1'b0, word_of(4), 1);
    check("col_level", level, 5);
    check("col_trig_index", trig_index, 3);
    rd_req = 1'b1;
    tick();
    check("col_pop0", rd_data, word_of(0));
    tick();
    check("col_pop1", rd_data, word_of(1));
    check("col_level2", level, 3);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    rd_req = 1'b0;
    model_arm();
    check("col_rearm_valid", rd_valid, 0);
    check("col_rearm_level", level, 0);
    check("col_rearm_done", done, 0);
    check("col_rearm_empty", rd_empty, 1);
    check("col_rearm_trig", triggered, 0);
    check("col_rearm_hold", rd_data, word_of(1));
    drive_cycle(1'b1, 1'b1, word_of(9), 0);
    check("col_armed_level", level, 1);
    read_all(1, 1'b0, 0);

    // Randomized captures against the queue model
    for (int r = 0; r < 10; r++) begin
      int popped;
      do_arm();
      for (int cyc = 0; cyc < 300; cyc++) begin
        drive_cycle($urandom_range(0, 3) != 0,
                    (cyc >= 40) || ($urandom_range(0, 9) == 0),
                    $urandom, $urandom_range(0, 7));
        if (m_done) break;
      end
      check("rand_done_in_budget", done, 1);
      if (!m_done) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        continue;
      end
      check("rand_level", level, model_stored());
      check("rand_wrapped", wrapped, hist.size() >= DEPTH);
      check("rand_trig_index", trig_index, m_trig_pos % DEPTH);
      popped = 0;
      for (int b = 0; b < 200 && popped < model_stored(); b++) begin
        bit r_req;
        r_req  = 1'($urandom_range(0, 1));
        rd_req = r_req;
        tick();
        if (r_req) begin
          check("rand_rd_valid", rd_valid, 1);
          check("rand_rd_data", rd_data, model_entry(popped));
          popped++;
        end else begin
          check("rand_idle_valid", rd_valid, 0);
        end
      end
      rd_req = 1'b0;
      check("rand_empty_end", rd_empty, 1);
      check("rand_level_end", level, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
